// File: rtl/l15_sched_pkg.sv
// Shared types and constants for the L1.5 request scheduler.
// Requester indices, FSM states and the request payload record.
package l15_sched_pkg;

    localparam int L15_NUM_REQ        = 3;
    localparam int L15_ADDR_W         = 64;
    localparam int L15_DATA_W         = 64;
    localparam int L15_TID_W          = 2;
    localparam int L15_MAX_OUT_STORES = 7;

    localparam int REQ_ICACHE = 0;
    localparam int REQ_DLOAD  = 1;
    localparam int REQ_DSTORE = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } sched_state_e;

    typedef struct packed {
        logic [L15_ADDR_W-1:0] addr;
        logic [L15_DATA_W-1:0] data;
        logic                  store;
        logic [L15_TID_W-1:0]  tid;
    } l15_req_t;

    function automatic int next_idx(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/l15_req_sched_if.sv
// Bundle of the requester-side and L1.5-side signals of the scheduler.
// Signal names are written from the scheduler's point of view.
interface l15_req_sched_if #(
    parameter int NUM_REQ        = 3,
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int TID_W          = 2,
    parameter int MAX_OUT_STORES = 7
);
    localparam int SRC_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUT_STORES + 1);

    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [NUM_REQ-1:0]        req_is_store_i;
    logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
    logic [NUM_REQ*DATA_W-1:0] req_data_i;
    logic [NUM_REQ*TID_W-1:0]  req_tid_i;
    logic                      l15_val_o;
    logic                      l15_ack_i;
    logic [ADDR_W-1:0]         l15_addr_o;
    logic [DATA_W-1:0]         l15_data_o;
    logic                      l15_store_o;
    logic [TID_W-1:0]          l15_tid_o;
    logic [SRC_W-1:0]          l15_src_o;
    logic                      store_ack_i;
    logic [CNT_W-1:0]          stores_out_o;
    logic                      busy_o;

    modport slave (
        input  req_valid_i, req_is_store_i, req_addr_i, req_data_i, req_tid_i,
        input  l15_ack_i, store_ack_i,
        output req_ready_o, l15_val_o, l15_addr_o, l15_data_o, l15_store_o,
        output l15_tid_o, l15_src_o, stores_out_o, busy_o
    );

    modport master (
        output req_valid_i, req_is_store_i, req_addr_i, req_data_i, req_tid_i,
        output l15_ack_i, store_ack_i,
        input  req_ready_o, l15_val_o, l15_addr_o, l15_data_o, l15_store_o,
        input  l15_tid_o, l15_src_o, stores_out_o, busy_o
    );

endinterface

// File: rtl/l15_req_sched_arb.sv
// Combinational round-robin pick: first set request bit at or after the
// pointer, wrapping modulo N. One-hot grant plus the winning index.
module rr_arb_mask #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW-1:0] w_j;
    logic          w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_j     = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_j = IW'((int'(i_ptr) + k) % N);
            if (!w_found && i_req[w_j]) begin
                w_found   = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_idx     = w_j;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/l15_req_sched.sv
// Round-robin scheduler of L1 miss/store requests onto the L1.5 channel,
// with a credit counter bounding unacknowledged stores.
//   state | meaning
//   IDLE  | arbitrate eligible requesters, latch winner's payload
//   SEND  | present latched request to the L1.5 until l15_ack_i
module l15_req_sched
    import l15_sched_pkg::*;
#(
    parameter int NUM_REQ        = L15_NUM_REQ,
    parameter int ADDR_W         = L15_ADDR_W,
    parameter int DATA_W         = L15_DATA_W,
    parameter int TID_W          = L15_TID_W,
    parameter int MAX_OUT_STORES = L15_MAX_OUT_STORES
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    l15_req_sched_if.slave bus
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_OUT_STORES + 1);

    sched_state_e      r_state;
    logic [IW-1:0]     r_ptr;
    logic [CW-1:0]     r_cnt;
    logic              r_val;
    logic              r_busy;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_store;
    logic [TID_W-1:0]  r_tid;
    logic [IW-1:0]     r_src;

    logic              w_full;
    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_arb_req;
    logic [NUM_REQ-1:0] w_gnt;
    logic [IW-1:0]     w_idx;
    logic              w_any;
    logic              w_accept;
    logic              w_acc_store;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [TID_W-1:0]  w_tid;

    // Eligibility looks only at the registered count, so a store_ack_i
    // frees a credit for arbitration one cycle later.
    assign w_full    = (r_cnt >= CW'(MAX_OUT_STORES));
    assign w_elig    = bus.req_valid_i & ~(bus.req_is_store_i & {NUM_REQ{w_full}});
    assign w_arb_req = (rst_ni && r_state == IDLE) ? w_elig : '0;

    rr_arb_mask #(.N(NUM_REQ), .IW(IW)) u_arb (
        .i_req (w_arb_req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_accept    = w_any;
    assign w_acc_store = w_accept && bus.req_is_store_i[w_idx];
    assign w_addr      = bus.req_addr_i[int'(w_idx)*ADDR_W +: ADDR_W];
    assign w_data      = bus.req_data_i[int'(w_idx)*DATA_W +: DATA_W];
    assign w_tid       = bus.req_tid_i[int'(w_idx)*TID_W +: TID_W];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_val   <= 1'b0;
            r_busy  <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_store <= 1'b0;
            r_tid   <= '0;
            r_src   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= SEND;
                        r_val   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_addr  <= w_addr;
                        r_data  <= w_data;
                        r_store <= bus.req_is_store_i[w_idx];
                        r_tid   <= w_tid;
                        r_src   <= w_idx;
                        r_ptr   <= IW'(next_idx(int'(w_idx), NUM_REQ));
                    end
                end
                SEND: begin
                    if (bus.l15_ack_i) begin
                        r_state <= IDLE;
                        r_val   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
            endcase

            // Accept and completion in the same cycle cancel out.
            case ({w_acc_store, bus.store_ack_i})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign bus.req_ready_o  = w_gnt;
    assign bus.l15_val_o    = r_val;
    assign bus.busy_o       = r_busy;
    assign bus.l15_addr_o   = r_addr;
    assign bus.l15_data_o   = r_data;
    assign bus.l15_store_o  = r_store;
    assign bus.l15_tid_o    = r_tid;
    assign bus.l15_src_o    = r_src;
    assign bus.stores_out_o = r_cnt;

    a_store_ack_underflow: assert property (
        @(posedge clk_i) disable iff (!rst_ni) !(bus.store_ack_i && r_cnt == '0)
    ) else $error("store_ack_i with no outstanding stores");

endmodule
